// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave backed by a word-addressed SRAM array with byte strobes.
// Write and read channels run as independent FSMs; every output comes straight from a flop.
module axi_lite_sram_slave #(
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MEM_DEPTH_WORDS    = 1024
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     Write_count
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int NB     = DW / 8;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int MEM_AW = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(MEM_DEPTH_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // W_IDLE collect AW/W | W_COMMIT write array | W_RESP hold B until BREADY
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;
  // R_IDLE accept AR | R_DATA hold R until RREADY
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [DW-1:0] mem [MEM_DEPTH_WORDS];

  w_state_e         w_state_q, w_state_d;
  r_state_e         r_state_q, r_state_d;
  logic             awready_q, awready_d;
  logic             wready_q, wready_d;
  logic             aw_held_q, aw_held_d;
  logic             w_held_q, w_held_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic [DW-1:0]    w_data_q, w_data_d;
  logic [NB-1:0]    w_strb_q, w_strb_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [31:0]      wcount_q, wcount_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;

  logic             aw_in_range;
  logic             ar_in_range;
  logic [IDX_W-1:0] ar_idx;
  logic             mem_wr_en;
  logic             unused_addr_lsbs;

  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_in_range = ({1'b0, aw_idx_q} < DEPTH_L);
  assign ar_in_range = ({1'b0, ar_idx} < DEPTH_L);
  assign mem_wr_en   = (w_state_q == W_COMMIT) && aw_in_range;

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wcount_d  = wcount_q;
    case (w_state_q)
      W_IDLE: begin
        awready_d = !aw_held_q;
        wready_d  = !w_held_q;
        if (S_AXI_AWVALID && awready_q) begin
          aw_held_d = 1'b1;
          aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          awready_d = 1'b0;
        end
        if (S_AXI_WVALID && wready_q) begin
          w_held_d = 1'b1;
          w_data_d = S_AXI_WDATA;
          w_strb_d = S_AXI_WSTRB;
          wready_d = 1'b0;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = W_COMMIT;
        end
      end
      W_COMMIT: begin
        bvalid_d  = 1'b1;
        bresp_d   = aw_in_range ? RESP_OKAY : RESP_SLVERR;
        if (aw_in_range) begin
          wcount_d = wcount_q + 32'd1;
        end
        w_state_d = W_RESP;
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // The array is read here before the commit edge, so a same-edge read sees old data.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = ar_in_range ? mem[ar_idx[MEM_AW-1:0]] : '0;
          rresp_d   = ar_in_range ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wcount_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wcount_q  <= wcount_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Array is never reset; reset also blocks a commit that lands on the same edge.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESETN && mem_wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (w_strb_q[i]) begin
          mem[aw_idx_q[MEM_AW-1:0]][8*i +: 8] <= w_data_q[8*i +: 8];
        end
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign Write_count   = wcount_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave: inputs driven and outputs sampled on the falling edge.
module tb_axi_lite_sram_slave;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          arstn;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready;
  logic [31:0]   wdata, rdata, wcount;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready, rvalid, rready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_lite_sram_slave #(
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_S_AXI_DATA_WIDTH(32),
    .MEM_DEPTH_WORDS(1024)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(arstn),
    .S_AXI_AWADDR(awaddr),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid),
    .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp),
    .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid),
    .S_AXI_RREADY(rready),
    .Write_count(wcount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // AW and W presented together; BREADY held low for 'stall' cycles after BVALID.
  task automatic wr(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [1:0] resp, input logic [31:0] cnt, input int stall);
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
    check("wr_awready_idle", 32'(awready), 32'd1);
    check("wr_wready_idle", 32'(wready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_awready_drop", 32'(awready), 32'd0);
    check("wr_wready_drop", 32'(wready), 32'd0);
    check("wr_bvalid_commit", 32'(bvalid), 32'd0);
    @(negedge clk);
    check("wr_bvalid", 32'(bvalid), 32'd1);
    check("wr_bresp", 32'(bresp), 32'(resp));
    check("wr_count", wcount, cnt);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("wr_stall_bvalid", 32'(bvalid), 32'd1);
      check("wr_stall_bresp", 32'(bresp), 32'(resp));
      check("wr_stall_awready", 32'(awready), 32'd0);
      check("wr_stall_wready", 32'(wready), 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("wr_bvalid_done", 32'(bvalid), 32'd0);
    check("wr_awready_back", 32'(awready), 32'd1);
    check("wr_wready_back", 32'(wready), 32'd1);
  endtask

  task automatic rd(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                    input logic [1:0] exp_resp, input int stall);
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    check("rd_arready_idle", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check("rd_rvalid", 32'(rvalid), 32'd1);
    check("rd_rdata", rdata, exp_data);
    check("rd_rresp", 32'(rresp), 32'(exp_resp));
    check("rd_arready_drop", 32'(arready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("rd_stall_rvalid", 32'(rvalid), 32'd1);
      check("rd_stall_rdata", rdata, exp_data);
      check("rd_stall_rresp", 32'(rresp), 32'(exp_resp));
      check("rd_stall_arready", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check("rd_rvalid_done", 32'(rvalid), 32'd0);
    check("rd_arready_back", 32'(arready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 32'(awready), 32'd0);
    check({tag, "_wready"}, 32'(wready), 32'd0);
    check({tag, "_arready"}, 32'(arready), 32'd0);
    check({tag, "_bvalid"}, 32'(bvalid), 32'd0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_bresp"}, 32'(bresp), 32'd0);
    check({tag, "_rresp"}, 32'(rresp), 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_count"}, wcount, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arstn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    arstn = 1'b1;
    @(negedge clk);
    check("rel_awready", 32'(awready), 32'd1);
    check("rel_wready", 32'(wready), 32'd1);
    check("rel_arready", 32'(arready), 32'd1);

    // Same-cycle AW/W, then read back
    wr(13'h010, 32'hDEADBEEF, 4'hF, 2'b00, 32'd1, 0);
    rd(13'h010, 32'hDEADBEEF, 2'b00, 0);

    // W first, AW three cycles later
    @(negedge clk);
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    check("wf_wready_drop", 32'(wready), 32'd0);
    check("wf_awready_open", 32'(awready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check("wf_bvalid_wait", 32'(bvalid), 32'd0);
    end
    awaddr = 13'h010; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("wf_awready_drop", 32'(awready), 32'd0);
    check("wf_bvalid_commit", 32'(bvalid), 32'd0);
    @(negedge clk);
    check("wf_bvalid", 32'(bvalid), 32'd1);
    check("wf_count", wcount, 32'd2);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("wf_bvalid_done", 32'(bvalid), 32'd0);

    // Byte-lane merge
    wr(13'h010, 32'h0000AA00, 4'b0010, 2'b00, 32'd3, 0);
    rd(13'h010, 32'hDEADAAEF, 2'b00, 0);

    // Out of range: word 1024
    wr(13'h1000, 32'h12345678, 4'hF, 2'b10, 32'd3, 0);
    rd(13'h1000, 32'h00000000, 2'b10, 0);

    // Back-pressure on B and R
    wr(13'h020, 32'h5A5A5A5A, 4'hF, 2'b00, 32'd4, 5);
    rd(13'h020, 32'h5A5A5A5A, 2'b00, 5);

    // Zero strobe: OKAY and counted, data untouched
    wr(13'h020, 32'hFFFFFFFF, 4'h0, 2'b00, 32'd5, 0);
    rd(13'h020, 32'h5A5A5A5A, 2'b00, 0);

    // Commit and AR on the same edge to word 4
    wr(13'h010, 32'h11111111, 4'hF, 2'b00, 32'd6, 0);
    @(negedge clk);
    awaddr = 13'h010; awvalid = 1'b1; wdata = 32'h22222222; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 13'h010; arvalid = 1'b1;
    check("se_bvalid_commit", 32'(bvalid), 32'd0);
    check("se_arready", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check("se_rvalid", 32'(rvalid), 32'd1);
    check("se_rdata_old", rdata, 32'h11111111);
    check("se_bvalid", 32'(bvalid), 32'd1);
    check("se_count", wcount, 32'd7);
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    check("se_bvalid_done", 32'(bvalid), 32'd0);
    check("se_rvalid_done", 32'(rvalid), 32'd0);
    rd(13'h010, 32'h22222222, 2'b00, 0);

    // Reset one cycle after the AW/W handshake aborts the write
    wr(13'h030, 32'h33333333, 4'hF, 2'b00, 32'd8, 0);
    @(negedge clk);
    awaddr = 13'h030; awvalid = 1'b1; wdata = 32'h44444444; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    arstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    arstn = 1'b1;
    @(negedge clk);
    check("mid_rel_awready", 32'(awready), 32'd1);
    check("mid_rel_arready", 32'(arready), 32'd1);
    check("mid_rel_bvalid", 32'(bvalid), 32'd0);
    rd(13'h030, 32'h33333333, 2'b00, 0);
    wr(13'h034, 32'h00000055, 4'hF, 2'b00, 32'd1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_sram_slave.md
AXI_LITE_SRAM_SLAVE -- requirements
Module: axi_lite_sram_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 12, byte-address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width; only 32 supported.
REQ-003 SHALL have parameter MEM_DEPTH_WORDS, default 1024, word count; power of two, at most 2^(C_S_AXI_ADDR_WIDTH-2).
REQ-004 SHALL have ports, clock and reset first:
- S_AXI_ACLK  in  1  sole clock; all logic on its rising edge.
- S_AXI_ARESETN  in  1  reset; synchronous, active-low.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWVALID  in  1  write-address valid.
- S_AXI_AWREADY  out  1  write-address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write-data valid.
- S_AXI_WREADY  out  1  write-data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write-response valid.
- S_AXI_BREADY  in  1  write-response ready.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARVALID  in  1  read-address valid.
- S_AXI_ARREADY  out  1  read-address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read-data valid.
- S_AXI_RREADY  in  1  read-data ready.
- Write_count  out  32  count of OKAY write commits.

Function
REQ-005 SHALL hold a MEM_DEPTH_WORDS x 32 array; word index = ADDR[C_S_AXI_ADDR_WIDTH-1:2]; ADDR[1:0] ignored.
REQ-006 SHALL treat word index >= MEM_DEPTH_WORDS as out-of-range: no array access, response SLVERR (2'b10); in-range response OKAY (2'b00).
REQ-007 All outputs SHALL be registered.
REQ-008 Handshake SHALL be VALID&&READY at a rising edge; the slave SHALL never wait for VALID before asserting READY.
REQ-009 Write channel: AW and W SHALL be accepted independently, in either order or the same cycle, each latched into a one-entry holding register.
REQ-010 AWREADY SHALL deassert the cycle after an AW handshake; WREADY likewise after a W handshake; neither SHALL reassert until the B handshake completes.
REQ-011 Write FSM states: W_IDLE (collecting AW/W) -> W_COMMIT (both held) -> W_RESP (BVALID=1) -> W_IDLE on B handshake.
REQ-012 In W_COMMIT the array SHALL be written: byte i updated only when WSTRB[i]=1; BVALID SHALL be 1 the next cycle (one cycle after the later of AW/W handshakes plus one commit cycle).
REQ-013 BVALID/BRESP SHALL hold stable until BREADY; AWREADY and WREADY SHALL reassert the cycle after the B handshake.
REQ-014 Write_count SHALL increment by 1 on each OKAY commit, wrap 2^32-1 -> 0, and not change on SLVERR.
REQ-015 Read FSM states: R_IDLE (ARREADY=1) -> R_DATA (RVALID=1) -> R_IDLE on R handshake.
REQ-016 On AR handshake ARREADY SHALL drop and the array SHALL be sampled; RVALID, RDATA, RRESP SHALL appear the next cycle; latency 1.
REQ-017 Out-of-range read SHALL return RDATA=0, RRESP=SLVERR.
REQ-018 RDATA/RRESP SHALL hold stable while RVALID=1 and RREADY=0; ARREADY SHALL reassert the cycle after the R handshake.
REQ-019 Read and write channels SHALL run concurrently; a read sampling the array on the same edge as a write commit to the same word SHALL return the old data.
REQ-020 WSTRB=4'b0000 in range SHALL leave the array unchanged but respond OKAY and count.

Reset
REQ-021 With S_AXI_ARESETN=0 at an edge: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, Write_count=0, FSMs to W_IDLE/R_IDLE, holding registers invalid.
REQ-022 AWREADY, WREADY, ARREADY SHALL be 1 on the first cycle after reset release.
REQ-023 Array contents SHALL NOT be reset; reset mid-transaction SHALL abort it with no response, and an uncommitted write SHALL not modify the array.

Verification
REQ-024 Bench SHALL cover:
- AW=0x010 and W=0xDEADBEEF, STRB=F, same cycle; BREADY=1 -> BVALID two cycles later, BRESP=00, Write_count=1; read 0x010 -> RDATA=0xDEADBEEF, RRESP=00, RVALID one cycle after AR.
- W first, AW three cycles later; then STRB=4'b0010, WDATA=0x0000AA00 to same word -> read 0xDEADAAEF.
- AW=0x1000 (word 1024, out of range) -> BRESP=10, Write_count unchanged; read 0x1000 -> RDATA=0, RRESP=10.
- BREADY/RREADY held low 5 cycles -> BVALID/RVALID and data stable, AWREADY/WREADY/ARREADY stay 0.
- Same-edge commit and AR to word 4 (old 0x11111111, new 0x22222222) -> read returns 0x11111111; next read returns 0x22222222.
- Reset asserted one cycle after AW handshake -> all outputs at reset values; word unchanged on later read.
